// File: rtl/seq_detect_param.sv
// seq_detect_param
// Serial pattern detector with a runtime-loadable pattern of PAT_LEN bits.
// The first bit received is compared against pat[PAT_LEN-1]. A registered
// pulse on out marks each detection, and hit_cnt keeps a saturating count
// of detections. OVERLAP selects whether the tail of one match may also
// begin the next match.

module seq_detect_param #(
   parameter int                 PAT_LEN     = 3,
   parameter logic [PAT_LEN-1:0] DEFAULT_PAT = 3'b101,
   parameter int                 OVERLAP     = 0,
   parameter int                 CNT_W       = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               signal,
   input  logic               pat_load,
   input  logic [PAT_LEN-1:0] pat_in,
   input  logic               cnt_clr,
   output logic               out,
   output logic [CNT_W-1:0]   hit_cnt
);

   localparam int                 FILL_W   = $clog2(PAT_LEN);
   localparam logic [FILL_W-1:0]  FILL_MAX = FILL_W'(PAT_LEN - 1);
   localparam logic [CNT_W-1:0]   CNT_MAX  = '1;

   logic [PAT_LEN-1:0] pat;
   logic [PAT_LEN-2:0] hist;
   logic [FILL_W-1:0]  fill;
   logic [PAT_LEN-1:0] shifted;
   logic               match;

   // The window being judged this edge is the stored history plus the
   // incoming bit; a match needs a full window and an accepted sample.
   always_comb begin
      shifted = {hist, signal};
      match   = 1'b0;
      if (en && !pat_load && (fill == FILL_MAX) && (shifted == pat)) begin
         match = 1'b1;
      end
   end

   // Pattern, history, fill level and detection pulse. A pattern load wins
   // over sampling and throws away the bit on that edge; in non-overlap
   // mode a match empties the window so its bits cannot be reused.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pat  <= DEFAULT_PAT;
         hist <= '0;
         fill <= '0;
         out  <= 1'b0;
      end else if (pat_load) begin
         pat  <= pat_in;
         fill <= '0;
         out  <= 1'b0;
      end else if (en) begin
         hist <= shifted[PAT_LEN-2:0];
         if (match && (OVERLAP == 0)) begin
            fill <= '0;
         end else if (fill != FILL_MAX) begin
            fill <= fill + FILL_W'(1);
         end
         out <= match;
      end else begin
         out <= 1'b0;
      end
   end

   // Saturating detection counter; a clear on the same edge as a match
   // leaves the counter at zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hit_cnt <= '0;
      end else if (cnt_clr) begin
         hit_cnt <= '0;
      end else if (match && (hit_cnt != CNT_MAX)) begin
         hit_cnt <= hit_cnt + CNT_W'(1);
      end
   end

endmodule

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 The block SHALL have parameter PAT_LEN, default 3, pattern length in bits (legal 2..16).
REQ-002 The block SHALL have parameter DEFAULT_PAT, default 3'b101 (PAT_LEN bits), pattern loaded at reset.
REQ-003 The block SHALL have parameter OVERLAP, default 0: 0 = non-overlapping detection, 1 = overlapping detection.
REQ-004 The block SHALL have parameter CNT_W, default 8, hit-counter width (legal 1..32).
REQ-005 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-007 The block SHALL have port en, input, 1, sample enable; signal is consumed only when high.
REQ-008 The block SHALL have port signal, input, 1, serial data bit.
REQ-009 The block SHALL have port pat_load, input, 1, loads pat_in as the new pattern.
REQ-010 The block SHALL have port pat_in, input, PAT_LEN, new pattern; bit PAT_LEN-1 is the first bit received.
REQ-011 The block SHALL have port cnt_clr, input, 1, synchronous clear of hit_cnt.
REQ-012 The block SHALL have port out, output, 1, registered one-cycle detection pulse.
REQ-013 The block SHALL have port hit_cnt, output, CNT_W, saturating count of detections.

Function
REQ-014 The block SHALL hold a pattern register pat, a history shift register hist (PAT_LEN-1 bits), and a fill counter fill (0..PAT_LEN-1).
REQ-015 On an edge with en=1 and pat_load=0: hist <= {hist, signal} (newest bit at LSB); fill increments, saturating at PAT_LEN-1.
REQ-016 Match SHALL be fill == PAT_LEN-1 and {hist, signal} == pat, with en=1 and pat_load=0.
REQ-017 out SHALL register match: high for exactly the one cycle following the edge that sampled the last pattern bit; otherwise 0.
REQ-018 OVERLAP=0: on a match edge fill SHALL be set to 0, so no bit of a matched sequence contributes to a later match.
REQ-019 OVERLAP=1: on a match edge fill SHALL remain PAT_LEN-1, so a suffix of a match may start the next one.
REQ-020 On an edge with en=0 (and pat_load=0): hist, fill and pat SHALL hold; out <= 0; signal is ignored.
REQ-021 pat_load=1 SHALL take priority over en: pat <= pat_in, fill <= 0, out <= 0; the signal bit on that edge is discarded.
REQ-022 hit_cnt SHALL increment by 1 on each match edge and saturate at 2^CNT_W-1 (no wrap).
REQ-023 cnt_clr=1 SHALL set hit_cnt to 0 on that edge; cnt_clr SHALL win over a simultaneous match (result 0).
REQ-024 cnt_clr SHALL NOT affect pat, hist, fill or out.
REQ-025 Detection latency: out SHALL rise exactly one clock after the edge sampling the final pattern bit; no combinational path from signal to out.

Reset
REQ-026 rst=0 SHALL immediately, independent of clk, force pat=DEFAULT_PAT, hist=0, fill=0, out=0, hit_cnt=0.
REQ-027 Reset asserted mid-sequence SHALL discard all partial history; after release, a full PAT_LEN bits are needed before any match.
REQ-028 First sampling edge after rst deasserts SHALL be treated as a normal edge.

Verification
REQ-029 Defaults, en=1, signal 1,0,1,0,1 on five edges -> out pulses once (after 3rd bit), hit_cnt=1.
REQ-030 OVERLAP=1, same stimulus 1,0,1,0,1 -> out pulses after 3rd and 5th bits, hit_cnt=2.
REQ-031 en gap: bits 1,0 with en=1, two edges en=0 (signal=0), then 1 with en=1 -> one pulse, out=0 during gap.
REQ-032 pat_load with pat_in=3'b110 after bits 1,1 -> fill cleared; then 1,1,0 -> one pulse; 1,0,1 -> no pulse.
REQ-033 CNT_W=2, five non-overlapping 101 sequences -> hit_cnt 1,2,3,3,3; cnt_clr on a match edge -> hit_cnt=0.
REQ-034 rst pulsed low between bits 1,0 and final 1 -> outputs zero immediately, no pulse on final 1; subsequent 1,0,1 -> one pulse.
